// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, digit count and active-low hex segment table for the scan controller
package seg7_pkg;
  localparam int DIGITS = 8;
  typedef enum logic {SHOW, BLANK} state_t;
  typedef struct packed {
    logic [31:0] data;
    logic [7:0] dp;
    logic [7:0] en;
  } disp_t;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/seg7_hex_decoder.sv
// seg7_hex_decoder: hex nibble to active-low gfedcba segment pattern
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nib];
endmodule

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: 8-digit multiplexed 7-segment scanner with blanking and frame-synchronous double buffering
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int SCAN_HZ = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input logic clk,
  input logic rst_n,
  input logic [31:0] data,
  input logic [7:0] dp_mask,
  input logic [7:0] en_mask,
  input logic load,
  output logic pending,
  output logic load_ack,
  output logic frame_tick,
  output logic [2:0] digit_idx,
  output logic [7:0] seg,
  output logic [7:0] an
);
  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int SHOW_LEN = DWELL - BLANK_CYCLES;
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_LEN - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  if (BLANK_CYCLES >= DWELL) begin : g_bad_blank
    $error("BLANK_CYCLES must be less than DWELL");
  end
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx_n;
  disp_t act, act_n, pend, pend_n, live;
  logic last_show, last_blank, slot_end, boundary;
  logic pending_n, ack_n;
  logic [3:0] nib;
  logic [6:0] hex;
  logic [7:0] an_n, seg_n;
  assign live = {data, dp_mask, en_mask};
  always_comb begin
    last_show = state == SHOW && cnt == SHOW_LAST;
    last_blank = state == BLANK && cnt == BLANK_LAST;
    slot_end = BLANK_CYCLES == 0 ? last_show : last_blank;
    boundary = slot_end && digit_idx == 3'(DIGITS - 1);
    state_n = state == SHOW ? ((last_show && BLANK_CYCLES != 0) ? BLANK : SHOW)
                            : (last_blank ? SHOW : BLANK);
    cnt_n = (last_show || last_blank) ? '0 : cnt + 1'b1;
    idx_n = slot_end ? digit_idx + 3'd1 : digit_idx;
    act_n = boundary ? (load ? live : (pending ? pend : act)) : act;
    pend_n = (load && !boundary) ? live : pend;
    pending_n = !boundary && (load || pending);
    ack_n = boundary && (load || pending);
  end
  assign nib = act_n.data[{idx_n, 2'b00} +: 4];
  seg7_hex_decoder u_dec (.nib(nib), .seg(hex));
  always_comb begin
    an_n = state_n == SHOW ? ~(8'(act_n.en[idx_n]) << idx_n) : 8'hFF;
    seg_n = (state_n == SHOW && act_n.en[idx_n]) ? {~act_n.dp[idx_n], hex} : 8'hFF;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= SHOW;
      cnt <= '0;
      digit_idx <= '0;
      act <= '0;
      pend <= '0;
      pending <= 1'b0;
      load_ack <= 1'b0;
      frame_tick <= 1'b0;
      an <= 8'hFF;
      seg <= 8'hFF;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      digit_idx <= idx_n;
      act <= act_n;
      pend <= pend_n;
      pending <= pending_n;
      load_ack <= ack_n;
      frame_tick <= boundary;
      an <= an_n;
      seg <= seg_n;
    end
endmodule
